// File: rtl/axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_sram_slave
// Brief    : AXI4-Lite word-addressed SRAM responder with independent read and
//            write FSMs. Defining LFSR_DELAY_EN draws each response delay from
//            an 8-bit LFSR instead of the fixed RD_LAT / WR_LAT parameters.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          RD_LAT    = 2,
    parameter int          WR_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_SPAN   = 32'(4 * DEPTH);
    localparam logic [7:0]  c_RD_LAT = 8'(RD_LAT);
    localparam logic [7:0]  c_WR_LAT = 8'(WR_LAT);
    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;

    localparam logic [1:0]  c_R_IDLE = 2'd0;
    localparam logic [1:0]  c_R_WAIT = 2'd1;
    localparam logic [1:0]  c_R_RESP = 2'd2;
    localparam logic [1:0]  c_W_IDLE = 2'd0;
    localparam logic [1:0]  c_W_WAIT = 2'd1;
    localparam logic [1:0]  c_W_RESP = 2'd2;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (off < c_SPAN);
    endfunction

    function automatic logic [c_IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return c_IDX_W'(off >> 2);
    endfunction

    logic [31:0] r_mem [DEPTH];

    logic [7:0]  w_rd_lat;
    logic [7:0]  w_wr_lat;

`ifdef LFSR_DELAY_EN
    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, stepping every cycle
    logic [7:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
    assign w_rd_lat = {5'd0, r_lfsr[2:0]};
    assign w_wr_lat = {5'd0, r_lfsr[2:0]};
`else
    assign w_rd_lat = c_RD_LAT;
    assign w_wr_lat = c_WR_LAT;
`endif

    // ------------------------------------------------------------------ read
    logic [1:0]  r_rd_state;
    logic [7:0]  r_rd_cnt;
    logic [31:0] r_araddr;
    logic        w_ar_hs;
    logic [31:0] w_rd_addr;
    logic        w_rd_ok;
    logic [31:0] w_rd_word;

    assign w_ar_hs   = arvalid & arready;
    // With zero delay the memory is sampled on the AR handshake edge itself
    assign w_rd_addr = (r_rd_state == c_R_IDLE) ? araddr : r_araddr;
    assign w_rd_ok   = in_range(w_rd_addr);
    assign w_rd_word = r_mem[word_idx(w_rd_addr)];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= c_R_IDLE;
            r_rd_cnt   <= 8'd0;
            r_araddr   <= 32'd0;
            arready    <= 1'b1;
            rvalid     <= 1'b0;
            rdata      <= 32'd0;
            rresp      <= c_OKAY;
        end else begin
            case (r_rd_state)
                c_R_IDLE: begin
                    if (w_ar_hs) begin
                        r_araddr <= araddr;
                        arready  <= 1'b0;
                        if (w_rd_lat == 8'd0) begin
                            r_rd_state <= c_R_RESP;
                            rvalid     <= 1'b1;
                            rresp      <= w_rd_ok ? c_OKAY : c_SLVERR;
                            rdata      <= w_rd_ok ? w_rd_word : 32'd0;
                        end else begin
                            r_rd_state <= c_R_WAIT;
                            r_rd_cnt   <= w_rd_lat - 8'd1;
                        end
                    end
                end
                c_R_WAIT: begin
                    if (r_rd_cnt == 8'd0) begin
                        r_rd_state <= c_R_RESP;
                        rvalid     <= 1'b1;
                        rresp      <= w_rd_ok ? c_OKAY : c_SLVERR;
                        rdata      <= w_rd_ok ? w_rd_word : 32'd0;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 8'd1;
                    end
                end
                c_R_RESP: begin
                    if (rready) begin
                        r_rd_state <= c_R_IDLE;
                        rvalid     <= 1'b0;
                        arready    <= 1'b1;
                    end
                end
                default: begin
                    r_rd_state <= c_R_IDLE;
                    rvalid     <= 1'b0;
                    arready    <= 1'b1;
                end
            endcase
        end
    end

    // ----------------------------------------------------------------- write
    logic [1:0]  r_wr_state;
    logic [7:0]  r_wr_cnt;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_aw_have;
    logic        w_w_have;
    logic [31:0] w_wr_addr;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic        w_wr_commit;

    assign w_aw_hs   = awvalid & awready;
    assign w_w_hs    = wvalid & wready;
    // A dropped ready means that channel's beat is already held in registers
    assign w_aw_have = ~awready | w_aw_hs;
    assign w_w_have  = ~wready | w_w_hs;
    assign w_wr_addr = awready ? awaddr : r_awaddr;
    assign w_wr_data = wready ? wdata : r_wdata;
    assign w_wr_strb = wready ? wstrb : r_wstrb;

    assign w_wr_commit = ((r_wr_state == c_W_IDLE) && w_aw_have && w_w_have && (w_wr_lat == 8'd0))
                      || ((r_wr_state == c_W_WAIT) && (r_wr_cnt == 8'd0));

    always_ff @(posedge clk) begin
        if (!rst && w_wr_commit && in_range(w_wr_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_strb[i]) begin
                    r_mem[word_idx(w_wr_addr)][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= c_W_IDLE;
            r_wr_cnt   <= 8'd0;
            r_awaddr   <= 32'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            awready    <= 1'b1;
            wready     <= 1'b1;
            bvalid     <= 1'b0;
            bresp      <= c_OKAY;
        end else begin
            case (r_wr_state)
                c_W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr <= awaddr;
                        awready  <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                        wready  <= 1'b0;
                    end
                    if (w_aw_have && w_w_have) begin
                        if (w_wr_commit) begin
                            r_wr_state <= c_W_RESP;
                            bvalid     <= 1'b1;
                            bresp      <= in_range(w_wr_addr) ? c_OKAY : c_SLVERR;
                        end else begin
                            r_wr_state <= c_W_WAIT;
                            r_wr_cnt   <= w_wr_lat - 8'd1;
                        end
                    end
                end
                c_W_WAIT: begin
                    if (w_wr_commit) begin
                        r_wr_state <= c_W_RESP;
                        bvalid     <= 1'b1;
                        bresp      <= in_range(w_wr_addr) ? c_OKAY : c_SLVERR;
                    end else begin
                        r_wr_cnt <= r_wr_cnt - 8'd1;
                    end
                end
                c_W_RESP: begin
                    if (bready) begin
                        r_wr_state <= c_W_IDLE;
                        bvalid     <= 1'b0;
                        awready    <= 1'b1;
                        wready     <= 1'b1;
                    end
                end
                default: begin
                    r_wr_state <= c_W_IDLE;
                    bvalid     <= 1'b0;
                    awready    <= 1'b1;
                    wready     <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
